// File: rtl/conv_result_collector_pkg.sv
// Shared definitions for the convolution result collector: FSM encoding,
// output-map geometry helpers and the write-time saturation function.
package conv_result_collector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SKIP    = 2'd1,
        ST_COLLECT = 2'd2,
        ST_READOUT = 2'd3
    } state_e;

    localparam int unsigned WIDE_W = 64;

    function automatic int mapW(input int imgWidth);
        return imgWidth - 1;
    endfunction

    function automatic int mapH(input int imgHeight);
        return imgHeight - 1;
    endfunction

    function automatic int mapN(input int imgWidth, input int imgHeight);
        return (imgWidth - 1) * (imgHeight - 1);
    endfunction

    // Counter/address width able to hold values 0..n-1, never narrower than one bit.
    function automatic int idxWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [WIDE_W-1:0] satClamp(input logic [WIDE_W-1:0] value,
                                                  input int unsigned   outW);
        logic [WIDE_W-1:0] maxVal;
        maxVal = (64'd1 << outW) - 64'd1;
        return (value > maxVal) ? maxVal : value;
    endfunction

endpackage

// File: rtl/conv_map_buffer.sv
// Simple dual-port register array holding the output feature map, with a
// registered read port that forwards a same-cycle write to the same address.
module conv_map_buffer
    import conv_result_collector_pkg::*;
#(
    parameter int DEPTH = 9,
    parameter int WIDTH = 16,
    parameter int AW    = idxWidth(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // A one-word map is written and read on the same edge, hence the bypass.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/conv_result_collector.sv
// Collects the valid 2x2 convolution outputs into a map buffer and replays them
// over valid/ready. Define CONV_COLLECT_SAT_EN to saturate instead of truncate.
module conv_result_collector
    import conv_result_collector_pkg::*;
#(
    parameter int IN_W       = 21,
    parameter int OUT_W      = 16,
    parameter int IMG_WIDTH  = 4,
    parameter int IMG_HEIGHT = 4,
    parameter int SKIP_FIRST = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             overrun
);

    localparam int OW        = mapW(IMG_WIDTH);
    localparam int OH        = mapH(IMG_HEIGHT);
    localparam int N         = mapN(IMG_WIDTH, IMG_HEIGHT);
    localparam int AW        = idxWidth(N);
    localparam int CW        = idxWidth(IMG_WIDTH);
    localparam int RW        = idxWidth(OH);
    localparam int SW        = idxWidth((SKIP_FIRST > 0) ? SKIP_FIRST : 1);
    localparam int SKIP_LAST = (SKIP_FIRST > 0) ? SKIP_FIRST - 1 : 0;

    state_e            state_q;
    logic [SW-1:0]     skip_cnt_q;
    logic [CW-1:0]     col_q;
    logic [RW-1:0]     row_q;
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic              busy_q;
    logic              overrun_q;

    logic              storeBeat;
    logic              lastStore;
    logic              handshake;
    logic              lastWord;
    logic              bufRe;
    logic [AW-1:0]     bufRaddr;
    logic [WIDE_W-1:0] wide_d;
    logic [OUT_W-1:0]  wdata_d;
    logic              unused_wide;

    assign storeBeat = (state_q == ST_COLLECT) && in_valid && (col_q != CW'(IMG_WIDTH - 1));
    assign lastStore = storeBeat && (col_q == CW'(OW - 1)) && (row_q == RW'(OH - 1));
    assign handshake = (state_q == ST_READOUT) && out_valid_q && out_ready;
    assign lastWord  = (rd_ptr_q == AW'(N - 1));

    // The first word is fetched on the final store so it is ready the next cycle.
    assign bufRe    = lastStore || (handshake && !lastWord);
    assign bufRaddr = lastStore ? '0 : rd_ptr_q + AW'(1);

`ifdef CONV_COLLECT_SAT_EN
    assign wide_d = satClamp(WIDE_W'(in_data), OUT_W);
`else
    assign wide_d = WIDE_W'(in_data);
`endif
    assign wdata_d     = wide_d[OUT_W-1:0];
    assign unused_wide = ^wide_d;

    conv_map_buffer #(
        .DEPTH (N),
        .WIDTH (OUT_W),
        .AW    (AW)
    ) u_buffer (
        .clk     (clk),
        .rst     (rst),
        .we_i    (rst && storeBeat),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata_d),
        .re_i    (bufRe),
        .raddr_i (bufRaddr),
        .rdata_o (out_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            skip_cnt_q  <= '0;
            col_q       <= '0;
            row_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        skip_cnt_q <= '0;
                        col_q      <= '0;
                        row_q      <= '0;
                        wr_ptr_q   <= '0;
                        rd_ptr_q   <= '0;
                        overrun_q  <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= (SKIP_FIRST > 0) ? ST_SKIP : ST_COLLECT;
                    end
                end
                ST_SKIP: begin
                    if (in_valid) begin
                        skip_cnt_q <= skip_cnt_q + SW'(1);
                        if (skip_cnt_q == SW'(SKIP_LAST)) begin
                            state_q <= ST_COLLECT;
                        end
                    end
                end
                ST_COLLECT: begin
                    // The last column position straddles two image rows and is dropped.
                    if (in_valid) begin
                        if (col_q == CW'(IMG_WIDTH - 1)) begin
                            col_q <= '0;
                            row_q <= row_q + RW'(1);
                        end else begin
                            wr_ptr_q <= wr_ptr_q + AW'(1);
                            if (lastStore) begin
                                state_q     <= ST_READOUT;
                                rd_ptr_q    <= '0;
                                out_valid_q <= 1'b1;
                                out_last_q  <= (N == 1);
                            end else begin
                                col_q <= col_q + CW'(1);
                            end
                        end
                    end
                end
                ST_READOUT: begin
                    if (in_valid) begin
                        overrun_q <= 1'b1;
                    end
                    if (handshake) begin
                        if (lastWord) begin
                            state_q     <= ST_IDLE;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            busy_q      <= 1'b0;
                        end else begin
                            rd_ptr_q   <= rd_ptr_q + AW'(1);
                            out_last_q <= (rd_ptr_q == AW'(N - 2));
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_conv_result_collector.sv
// Directed bench for conv_result_collector with a 4x4 image and two fill beats;
// expected maps are hand-computed (CONV_COLLECT_SAT_EN selects the width case).
module tb_conv_result_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [20:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;
    logic        overrun;

    int vectors     = 0;
    int miscompares = 0;

    // Beats 0..12 after two fill beats, minus the straddling beats 5 and 9.
    int expMap [9] = '{2, 3, 4, 6, 7, 8, 10, 11, 12};
    int readyPat [4] = '{1, 0, 0, 1};

`ifdef CONV_COLLECT_SAT_EN
    localparam int BIG_EXP = 65535;
`else
    localparam int BIG_EXP = 4464;
`endif

    conv_result_collector dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Starts a frame and feeds beats 0..12, optionally with idle gaps and a stray start pulse.
    task automatic applyStimulus(input bit withGaps, input bit bigFirst, input bit startGlitch);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < 13; i++) begin
            in_valid = 1'b1;
            in_data  = (bigFirst && i == 2) ? 21'd70000 : 21'(i);
            tick();
            if (withGaps && i < 12) begin
                in_valid = 1'b0;
                start    = startGlitch;
                tick();
                start = 1'b0;
            end
        end
        in_valid = 1'b0;
        checkOutput("first_valid_latency", 32'(out_valid), 32'd1);
    endtask

    // Drains the replay, checking every word in order and its hold under backpressure.
    task automatic replay(input bit toggleReady, input bit injectIn, input bit bigFirst);
        int idx = 0;
        int cyc = 0;
        int expWord;
        while (idx < 9 && cyc < 200) begin
            out_ready = toggleReady ? readyPat[cyc % 4][0] : 1'b1;
            in_valid  = injectIn;
            expWord   = (bigFirst && idx == 0) ? BIG_EXP : expMap[idx];
            checkOutput("replay_valid", 32'(out_valid), 32'd1);
            checkOutput("replay_data", 32'(out_data), 32'(expWord));
            if (out_valid && out_ready) begin
                checkOutput("replay_last", 32'(out_last), (idx == 8) ? 32'd1 : 32'd0);
                idx++;
            end
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput("replay_count", 32'(idx), 32'd9);
        checkOutput("valid_after_last", 32'(out_valid), 32'd0);
        checkOutput("busy_after_last", 32'(busy), 32'd0);
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        checkOutput("reset_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_last", 32'(out_last), 32'd0);
        checkOutput("reset_data", 32'(out_data), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_overrun", 32'(overrun), 32'd0);

        $display("[TB] idle ignores in_valid without start");
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 21'd5;
        repeat (3) tick();
        checkOutput("idle_valid", 32'(out_valid), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        in_valid = 1'b0;
        tick();

        $display("[TB] nominal frame");
        applyStimulus(1'b0, 1'b0, 1'b0);
        replay(1'b0, 1'b0, 1'b0);

        $display("[TB] backpressure frame");
        applyStimulus(1'b0, 1'b0, 1'b0);
        replay(1'b1, 1'b0, 1'b0);

        $display("[TB] gapped input with stray start");
        applyStimulus(1'b1, 1'b0, 1'b1);
        replay(1'b0, 1'b0, 1'b0);

        $display("[TB] overrun during readout");
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("overrun_before", 32'(overrun), 32'd0);
        replay(1'b0, 1'b1, 1'b0);
        checkOutput("overrun_set", 32'(overrun), 32'd1);
        tick();
        checkOutput("overrun_sticky", 32'(overrun), 32'd1);

        $display("[TB] start clears overrun, then reset mid-collect");
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("overrun_cleared", 32'(overrun), 32'd0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 21'(i);
            tick();
        end
        in_valid = 1'b0;
        rst      = 1'b0;
        tick();
        rst = 1'b1;
        checkOutput("midreset_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_overrun", 32'(overrun), 32'd0);
        in_valid = 1'b1;
        repeat (12) tick();
        in_valid = 1'b0;
        checkOutput("abandoned_no_output", 32'(out_valid), 32'd0);
        checkOutput("abandoned_busy", 32'(busy), 32'd0);

        $display("[TB] wide input reduction");
        applyStimulus(1'b0, 1'b1, 1'b0);
        replay(1'b0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
